// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared logic-unit arbiter.
// The arbiter uses the slave modport; the requester side uses the master modport.
interface logic_unit_arbiter_if #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise logic unit among NREQ requesters.
// One transaction at a time: accept (IDLE) -> compute (EXEC) -> hold response (RESP).
module logic_unit_arbiter #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_id;
    logic           found;
    logic           accept;

    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [IDW-1:0] id_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_err_q;

    logic [W-1:0]   result;
    logic           result_err;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                found  = 1'b1;
                gnt_id = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    assign accept   = (state_q == S_IDLE) && found;
    assign rr_ptr_d = IDW'((int'(gnt_id) + 1) % NREQ);

    assign bus.req_ready = (accept && !rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (op_q)
            3'd0:    result = a_q & b_q;
            3'd1:    result = a_q | b_q;
            3'd2:    result = ~a_q;
            3'd3:    result = ~(a_q & b_q);
            3'd4:    result = ~(a_q | b_q);
            3'd5:    result = a_q ^ b_q;
            3'd6:    result = ~(a_q ^ b_q);
            default: result_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= bus.req_op[3*gnt_id +: 3];
                a_q      <= bus.req_a[W*gnt_id +: W];
                b_q      <= bus.req_b[W*gnt_id +: W];
                id_q     <= gnt_id;
                rr_ptr_q <= rr_ptr_d;
            end
            if (state_q == S_EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_data_q  <= result;
                rsp_err_q   <= result_err;
            end
            // Only valid clears on handshake; id/data/err keep their last values.
            if (state_q == S_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
